aesl_deadlock_event_log: RTL and testbench

AESL_DEADLOCK_EVENT_LOG -- requirements
Module: aesl_deadlock_event_log

---
 rtl/aesl_deadlock_event_log_pkg.sv | 28 ++
 rtl/aesl_dl_event_fifo.sv | 59 +++++
 rtl/aesl_deadlock_event_log.sv | 115 +++++++++++
 tb/tb_aesl_deadlock_event_log.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aesl_deadlock_event_log_pkg.sv
// Shared types and record layout for the deadlock event logger.
// A record is {timestamp, origin, blocked snapshot}, with the MSB first.
package aesl_deadlock_event_log_pkg;

    typedef enum logic {
        IDLE,
        HOLD
    } cap_state_e;

    localparam logic [15:0] EVENT_CNT_MAX = 16'hFFFF;

    function automatic int rec_width(input int ts_w, input int n_proc);
        return ts_w + 2 * n_proc;
    endfunction

    function automatic int blocked_lsb();
        return 0;
    endfunction

    function automatic int origin_lsb(input int n_proc);
        return n_proc;
    endfunction

    function automatic int ts_lsb(input int n_proc);
        return 2 * n_proc;
    endfunction

endpackage

// File: rtl/aesl_dl_event_fifo.sv
// Record FIFO for the deadlock event logger. Pointers carry one extra wrap bit.
// rd_data_o reads as zero whenever the FIFO is empty.
module aesl_dl_event_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int DEPTH_LOG2 = $clog2(DEPTH);

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic                do_wr;
    logic                do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    // NOTE: always_comb gives every output a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset. Only the pointers decide validity,
    // and the output is masked to zero while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/aesl_deadlock_event_log.sv
// Logs deadlock detections as timestamped records into a FIFO. It also counts
// detections and raises sticky overflow and hang flags.
module aesl_deadlock_event_log
    import aesl_deadlock_event_log_pkg::*;
#(
    parameter int N_PROC      = 4,
    parameter int DEPTH       = 4,
    parameter int TS_W        = 32,
    parameter int HANG_THRESH = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dl_detect,
    input  logic [N_PROC-1:0]        origin,
    input  logic [N_PROC-1:0]        proc_blocked,
    input  logic                     clr_sticky,
    output logic                     rd_valid,
    output logic [TS_W+2*N_PROC-1:0] rd_data,
    input  logic                     rd_ready,
    output logic                     overflow,
    output logic                     hang,
    output logic [15:0]              event_cnt
);

    localparam int REC_W = rec_width(TS_W, N_PROC);
    localparam int HC_W  = $clog2(HANG_THRESH + 1);
    localparam logic [HC_W-1:0] HANG_MAX = HC_W'(HANG_THRESH);

    cap_state_e       state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [HC_W-1:0]  hang_cnt_q, hang_cnt_d;
    logic             hang_q, hang_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      event_cnt_q, event_cnt_d;

    logic             capture;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;
    logic             all_blocked;
    logic             hang_set;
    logic [REC_W-1:0] record;

    assign capture     = (state_q == IDLE) && dl_detect;
    assign drop        = capture && fifo_full && !rd_ready;
    assign all_blocked = (&proc_blocked) && !dl_detect;

    always_comb begin
        record = '0;
        record[blocked_lsb() +: N_PROC]     = proc_blocked;
        record[origin_lsb(N_PROC) +: N_PROC] = origin;
        record[ts_lsb(N_PROC) +: TS_W]      = ts_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dl_detect)  state_d = HOLD;
            HOLD:    if (!dl_detect) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ts_d = ts_q + 1'b1;

        event_cnt_d = event_cnt_q;
        if (capture && event_cnt_q != EVENT_CNT_MAX) event_cnt_d = event_cnt_q + 1'b1;

        hang_cnt_d = '0;
        if (all_blocked) hang_cnt_d = (hang_cnt_q == HANG_MAX) ? HANG_MAX : hang_cnt_q + 1'b1;

        // The set term is ORed in last, so a set wins over a clear in the same cycle.
        hang_set   = all_blocked && (hang_cnt_d == HANG_MAX);
        hang_d     = (hang_q && !clr_sticky) || hang_set;
        overflow_d = (overflow_q && !clr_sticky) || drop;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ts_q        <= '0;
            hang_cnt_q  <= '0;
            hang_q      <= 1'b0;
            overflow_q  <= 1'b0;
            event_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            hang_cnt_q  <= hang_cnt_d;
            hang_q      <= hang_d;
            overflow_q  <= overflow_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    aesl_dl_event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (capture),
        .wr_data_i (record),
        .rd_en_i   (rd_ready),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .rd_data_o (rd_data)
    );

    assign rd_valid  = !fifo_empty;
    assign overflow  = overflow_q;
    assign hang      = hang_q;
    assign event_cnt = event_cnt_q;

endmodule

// File: tb/tb_aesl_deadlock_event_log.sv
// Scoreboard bench for aesl_deadlock_event_log: the stimulus pushes the expected
// records, and an independent monitor pops and compares them on each read handshake.
module tb_aesl_deadlock_event_log;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dl_detect = 1'b0;
    logic [3:0]  origin = '0;
    logic [3:0]  proc_blocked = '0;
    logic        clr_sticky = 1'b0;
    logic        rd_valid;
    logic [39:0] rd_data;
    logic        rd_ready = 1'b0;
    logic        overflow;
    logic        hang;
    logic [15:0] event_cnt;

    int          n_total = 0;
    int          n_bad = 0;
    bit [31:0]   cyc;
    logic [39:0] sb [$];

    aesl_deadlock_event_log dut (
        .clock        (clock),
        .reset        (reset),
        .dl_detect    (dl_detect),
        .origin       (origin),
        .proc_blocked (proc_blocked),
        .clr_sticky   (clr_sticky),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .overflow     (overflow),
        .hang         (hang),
        .event_cnt    (event_cnt)
    );

    always #5 clock = ~clock;

    // Reference timestamp: counts the rising edges since reset was released.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= '0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: samples just before each rising edge, where a handshake pops the head.
    initial begin
        forever begin
            @(negedge clock);
            #4;
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL rec_extra: actual=%0h expected=none", rd_data);
                end else begin
                    check("rec", {24'h0, rd_data}, {24'h0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // One detection pulse. The expected record is queued only if the FIFO can take it.
    task automatic pulse(input logic [3:0] o, input logic [3:0] b, input bit wrap_ts);
        logic [31:0] ts_exp;
        @(negedge clock);
        ts_exp       = wrap_ts ? 32'd1 : cyc;
        dl_detect    = 1'b1;
        origin       = o;
        proc_blocked = b;
        if (sb.size() < 4 || rd_ready) sb.push_back({ts_exp, o, b});
        @(negedge clock);
        dl_detect = 1'b0;
        @(negedge clock);
    endtask

    task automatic drain(input int n);
        @(negedge clock);
        rd_ready = 1'b1;
        repeat (n) @(negedge clock);
        rd_ready = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        #3;
        check("rst_valid", {63'h0, rd_valid}, 64'h0);
        check("rst_data", {24'h0, rd_data}, 64'h0);
        check("rst_evcnt", {48'h0, event_cnt}, 64'h0);
        check("rst_ovf", {63'h0, overflow}, 64'h0);
        check("rst_hang", {63'h0, hang}, 64'h0);
        @(negedge clock);
        reset = 1'b1;

        // Single detection held high for cycles 10..20.
        for (int i = 0; i < 100 && cyc != 10; i++) @(negedge clock);
        dl_detect    = 1'b1;
        origin       = 4'b0010;
        proc_blocked = 4'b1011;
        sb.push_back({32'd10, 4'b0010, 4'b1011});
        #1 check("single_valid_c10", {63'h0, rd_valid}, 64'h0);
        @(negedge clock);
        check("single_valid_c11", {63'h0, rd_valid}, 64'h1);
        check("single_evcnt", {48'h0, event_cnt}, 64'd1);
        repeat (9) @(negedge clock);
        dl_detect = 1'b0;
        @(negedge clock);
        check("single_evcnt_hold", {48'h0, event_cnt}, 64'd1);
        drain(1);
        check("single_drained", {63'h0, rd_valid}, 64'h0);

        // Overflow: five pulses, no reads. The fifth record is dropped; origin 0 is kept as 0.
        pulse(4'b0001, 4'b0011, 1'b0);
        pulse(4'b0010, 4'b0101, 1'b0);
        pulse(4'b0100, 4'b1001, 1'b0);
        pulse(4'b0000, 4'b0110, 1'b0);
        pulse(4'b1000, 4'b1100, 1'b0);
        check("ovf_set", {63'h0, overflow}, 64'h1);
        check("ovf_evcnt", {48'h0, event_cnt}, 64'd6);
        @(negedge clock);
        clr_sticky = 1'b1;
        @(negedge clock);
        clr_sticky = 1'b0;
        check("ovf_cleared", {63'h0, overflow}, 64'h0);
        check("ovf_clr_evcnt", {48'h0, event_cnt}, 64'd6);
        check("ovf_clr_valid", {63'h0, rd_valid}, 64'h1);

        // Full FIFO: a capture and a pop in the same cycle.
        @(negedge clock);
        rd_ready     = 1'b1;
        dl_detect    = 1'b1;
        origin       = 4'b0101;
        proc_blocked = 4'b1110;
        sb.push_back({cyc, 4'b0101, 4'b1110});
        @(negedge clock);
        rd_ready  = 1'b0;
        dl_detect = 1'b0;
        check("fullpop_ovf", {63'h0, overflow}, 64'h0);
        check("fullpop_evcnt", {48'h0, event_cnt}, 64'd7);
        drain(4);
        check("fullpop_drained", {63'h0, rd_valid}, 64'h0);
        check("fullpop_sb", 64'(sb.size()), 64'h0);

        // Hang: 1024 consecutive all-blocked cycles.
        @(negedge clock);
        proc_blocked = 4'b1111;
        repeat (1023) @(posedge clock);
        #1 check("hang_1023", {63'h0, hang}, 64'h0);
        @(posedge clock);
        #1 check("hang_1024", {63'h0, hang}, 64'h1);
        @(negedge clock);
        clr_sticky = 1'b1;
        @(posedge clock);
        #1 check("hang_set_wins", {63'h0, hang}, 64'h1);
        @(negedge clock);
        proc_blocked = 4'b0000;
        @(posedge clock);
        #1 check("hang_cleared", {63'h0, hang}, 64'h0);
        @(negedge clock);
        clr_sticky = 1'b0;

        // Hang repeat: a single unblocked cycle at cycle 500 restarts the count.
        proc_blocked = 4'b1111;
        repeat (499) @(negedge clock);
        proc_blocked = 4'b0111;
        @(negedge clock);
        proc_blocked = 4'b1111;
        repeat (600) @(negedge clock);
        check("hang_interrupted", {63'h0, hang}, 64'h0);
        check("hang_evcnt", {48'h0, event_cnt}, 64'd7);
        proc_blocked = 4'b0000;

        // Reset mid-stream with three records queued.
        pulse(4'b0001, 4'b0001, 1'b0);
        pulse(4'b0010, 4'b0010, 1'b0);
        pulse(4'b0100, 4'b0100, 1'b0);
        check("pre_rst_valid", {63'h0, rd_valid}, 64'h1);
        @(negedge clock);
        dl_detect    = 1'b1;
        origin       = 4'b1000;
        proc_blocked = 4'b0111;
        #2 reset = 1'b0;
        sb.delete();
        #1;
        check("midrst_valid", {63'h0, rd_valid}, 64'h0);
        check("midrst_evcnt", {48'h0, event_cnt}, 64'h0);
        check("midrst_data", {24'h0, rd_data}, 64'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        sb.push_back({32'd0, 4'b1000, 4'b0111});
        @(negedge clock);
        check("postrst_valid", {63'h0, rd_valid}, 64'h1);
        repeat (2) @(negedge clock);
        dl_detect = 1'b0;
        check("postrst_evcnt", {48'h0, event_cnt}, 64'd1);
        drain(2);
        check("postrst_drained", {63'h0, rd_valid}, 64'h0);

        // Timestamp wrap: force all-ones, then capture two cycles later; ts logs as 1.
        @(negedge clock);
        force dut.ts_q = 32'hFFFF_FFFF;
        #1 release dut.ts_q;
        @(negedge clock);
        pulse(4'b0100, 4'b1010, 1'b1);
        check("wrap_evcnt", {48'h0, event_cnt}, 64'd2);
        drain(1);
        check("wrap_drained", {63'h0, rd_valid}, 64'h0);

        repeat (2) @(negedge clock);
        check("sb_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
